// File: rtl/lcd_read_ctrl.sv
// rtl/lcd_read_ctrl.sv - 8080-style LCD read controller: command write, bus turnaround, RD-strobed reads
module lcd_read_ctrl #(
  parameter logic [7:0] WR_LO = 8'd2,
  parameter logic [7:0] WR_HI = 8'd2,
  parameter logic [7:0] TURN  = 8'd2,
  parameter logic [7:0] RD_LO = 8'd8,
  parameter logic [7:0] RD_HI = 8'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [3:0]  num_reads,
  input  logic [15:0] lcd_data_in,
  output logic [15:0] lcd_data_out,
  output logic        lcd_data_oe,
  output logic        cs,
  output logic        rs,
  output logic        wr,
  output logic        rd,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_LO, S_CMD_HI, S_TURN, S_RD_LO, S_RD_HI, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cmd_q;
  logic        phase_end;
  logic [7:0]  phase_len;

  logic [15:0] dout_d;
  logic        oe_d, cs_d, rs_d, wr_d, rd_d, busy_d, valid_d, done_d;
  logic [7:0]  cmd_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      cnt_q        <= 4'd0;
      cmd_q        <= 8'd0;
      lcd_data_out <= 16'd0;
      lcd_data_oe  <= 1'b0;
      cs           <= 1'b1;
      rs           <= 1'b1;
      wr           <= 1'b1;
      rd           <= 1'b1;
      busy         <= 1'b0;
      rd_data      <= 16'd0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q <= state_d;
      // The timer restarts on every phase change and idles at zero.
      if (state_d != state_q || state_q == S_IDLE)
        timer_q <= 8'd0;
      else
        timer_q <= timer_q + 8'd1;
      if (state_q == S_IDLE && start) begin
        cmd_q <= cmd;
        cnt_q <= num_reads;
      end else if (state_q == S_RD_HI && phase_end) begin
        cnt_q <= cnt_q - 4'd1;
      end
      lcd_data_out <= dout_d;
      lcd_data_oe  <= oe_d;
      cs           <= cs_d;
      rs           <= rs_d;
      wr           <= wr_d;
      rd           <= rd_d;
      busy         <= busy_d;
      rd_valid     <= valid_d;
      done         <= done_d;
      if (valid_d)
        rd_data <= lcd_data_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_len = 8'd1;
    case (state_q)
      S_CMD_LO: phase_len = WR_LO;
      S_CMD_HI: phase_len = WR_HI;
      S_TURN:   phase_len = TURN;
      S_RD_LO:  phase_len = RD_LO;
      S_RD_HI:  phase_len = RD_HI;
      default:  phase_len = 8'd1;
    endcase
    phase_end = (timer_q == phase_len - 8'd1);
    case (state_q)
      S_IDLE:   if (start) state_d = S_CMD_LO;
      S_CMD_LO: if (phase_end) state_d = S_CMD_HI;
      S_CMD_HI: if (phase_end) state_d = (cnt_q == 4'd0) ? S_FINISH : S_TURN;
      S_TURN:   if (phase_end) state_d = S_RD_LO;
      S_RD_LO:  if (phase_end) state_d = S_RD_HI;
      S_RD_HI:  if (phase_end) state_d = (cnt_q == 4'd1) ? S_FINISH : S_RD_LO;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so the registered pins line up with it.
  always_comb begin
    cmd_use = (state_q == S_IDLE) ? cmd : cmd_q;
    dout_d  = 16'd0;
    oe_d    = 1'b0;
    cs_d    = 1'b1;
    rs_d    = 1'b1;
    wr_d    = 1'b1;
    rd_d    = 1'b1;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_q == S_RD_LO) && phase_end;
    case (state_d)
      S_CMD_LO: begin
        cs_d = 1'b0; rs_d = 1'b0; wr_d = 1'b0; oe_d = 1'b1;
        dout_d = {8'h00, cmd_use};
      end
      S_CMD_HI: begin
        cs_d = 1'b0; rs_d = 1'b0; oe_d = 1'b1;
        dout_d = {8'h00, cmd_use};
      end
      S_TURN:   cs_d = 1'b0;
      S_RD_LO:  begin cs_d = 1'b0; rd_d = 1'b0; end
      S_RD_HI:  cs_d = 1'b0;
      S_FINISH: done_d = 1'b1;
      default:  done_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// tb/tb_lcd_read_ctrl.sv - randomized bench for lcd_read_ctrl against a timing-formula model
module tb_lcd_read_ctrl;
  localparam int WRL = 2, WRH = 2, TRN = 2, RDL = 8, RDH = 6, PER = RDL + RDH;
  localparam int C0 = WRL + WRH + TRN;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  cmd = 8'd0;
  logic [3:0]  num_reads = 4'd0;
  logic [15:0] lcd_data_in = 16'd0;
  logic [15:0] lcd_data_out, rd_data;
  logic        lcd_data_oe, cs, rs, wr, rd, busy, rd_valid, done;

  lcd_read_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .num_reads(num_reads),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .cs(cs), .rs(rs), .wr(wr), .rd(rd), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int tot(input int n);
    return (n == 0) ? WRL + WRH + 1 : C0 + n * PER + 1;
  endfunction

  // Model: a transaction is an offset into a timeline whose shape follows from the phase lengths.
  bit          m_active = 1'b0;
  int          m_off = 0, m_n = 0;
  logic [7:0]  m_cmd = 8'd0;
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] words [16];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_off    <= 0;
      exp_rd   <= 16'd0;
    end else if (m_active) begin
      if (m_n > 0 && m_off >= C0 && m_off < C0 + m_n * PER && (m_off - C0) % PER == RDL - 1)
        exp_rd <= words[(m_off - C0) / PER];
      if (m_off == tot(m_n) - 1) begin
        m_active <= 1'b0;
        m_off    <= 0;
      end else begin
        m_off <= m_off + 1;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_off    <= 0;
      m_cmd    <= cmd;
      m_n      <= int'(num_reads);
    end
  end

  int          busy_cyc, wr_lo_cyc, rd_lo_cyc, done_cnt, done_cyc;
  logic [15:0] wr_dout;
  logic        wr_rs;
  logic [15:0] vq[$];
  int          cq[$];

  task automatic clear_stats();
    busy_cyc = 0; wr_lo_cyc = 0; rd_lo_cyc = 0; done_cnt = 0; done_cyc = 0;
    wr_dout = 16'd0; wr_rs = 1'b1;
    vq.delete(); cq.delete();
  endtask

  always @(negedge clk) begin
    logic        e_cs, e_rs, e_wr, e_rd, e_oe, e_busy, e_done, e_v;
    logic [15:0] e_do, drive;
    int          j, ri;
    e_cs = 1; e_rs = 1; e_wr = 1; e_rd = 1; e_oe = 0; e_busy = 0; e_done = 0; e_v = 0;
    e_do = 16'd0;
    drive = 16'($urandom);
    if (m_active) begin
      e_busy = 1; e_cs = 0;
      if (m_off < WRL) begin
        e_rs = 0; e_wr = 0; e_oe = 1; e_do = {8'h00, m_cmd};
      end else if (m_off < WRL + WRH) begin
        e_rs = 0; e_oe = 1; e_do = {8'h00, m_cmd};
      end else if (m_off == tot(m_n) - 1) begin
        e_cs = 1; e_done = 1;
      end else if (m_off >= C0) begin
        j  = (m_off - C0) % PER;
        ri = (m_off - C0) / PER;
        if (j < RDL) e_rd = 0;
        if (j == RDL) e_v = 1;
        if (j == RDL - 1) drive = words[ri];
      end
    end
    chk("cs", cs, e_cs);
    chk("rs", rs, e_rs);
    chk("wr", wr, e_wr);
    chk("rd", rd, e_rd);
    chk("oe", lcd_data_oe, e_oe);
    chk("data_out", lcd_data_out, e_do);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rd_valid", rd_valid, e_v);
    chk("rd_data", rd_data, exp_rd);
    chk("wr_rd_overlap", int'(!wr && !rd), 0);
    chk("oe_with_rd", int'(lcd_data_oe && !rd), 0);
    chk("cs_in_busy", int'(busy && !done && cs), 0);
    if (busy) busy_cyc++;
    if (!wr) begin wr_lo_cyc++; wr_dout = lcd_data_out; wr_rs = rs; end
    if (!rd) rd_lo_cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd_valid) begin vq.push_back(rd_data); cq.push_back(cyc); end
    lcd_data_in = drive;
  end

  task automatic wait_idle();
    for (int k = 0; k < 1000 && m_active; k++) begin
      @(posedge clk); #2;
    end
    chk("txn_timeout", int'(m_active), 0);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [3:0] n);
    clear_stats();
    cmd = c; num_reads = n; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reads(input string name, input int n);
    chk({name, "_count"}, vq.size(), n);
    for (int k = 0; k < vq.size() && k < n; k++) chk({name, "_word"}, vq[k], words[k]);
  endtask

  initial begin
    int target, n;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs", cs, 1); chk("rst_rs", rs, 1); chk("rst_wr", wr, 1); chk("rst_rd", rd, 1);
    chk("rst_oe", lcd_data_oe, 0); chk("rst_dout", lcd_data_out, 0); chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0); chk("rst_valid", rd_valid, 0); chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #2;

    words[0] = 16'h0000; words[1] = 16'h0000; words[2] = 16'h0098; words[3] = 16'h0006;
    run_txn(8'hD3, 4'd4);
    check_reads("id", 4);
    if (vq.size() == 4) begin
      chk("id_w2", vq[2], 16'h0098);
      chk("id_w3", vq[3], 16'h0006);
      for (int k = 0; k < 3; k++) chk("id_spacing", cq[k + 1] - cq[k], 14);
      chk("id_last_to_done", done_cyc - cq[3], 6);
    end
    chk("id_busy_cycles", busy_cyc, 63);
    chk("id_wr_low", wr_lo_cyc, 2);
    chk("id_wr_data", wr_dout, 16'h00D3);
    chk("id_wr_rs", wr_rs, 0);
    chk("id_done_cnt", done_cnt, 1);

    run_txn(8'h29, 4'd0);
    chk("co_busy_cycles", busy_cyc, 5);
    chk("co_rd_low", rd_lo_cyc, 0);
    chk("co_valids", vq.size(), 0);
    chk("co_wr_low", wr_lo_cyc, 2);
    chk("co_wr_data", wr_dout, 16'h0029);
    chk("co_done_cnt", done_cnt, 1);
    @(posedge clk); #2;
    chk("co_cs_after", cs, 1);

    clear_stats();
    words[0] = 16'h5A5A;
    cmd = 8'h0A; num_reads = 4'd1; start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      cmd = 8'($urandom);
    end
    start = 1'b0;
    wait_idle();
    chk("hold_done_cnt", done_cnt, 10);
    chk("hold_busy_cycles", busy_cyc, 210);
    chk("hold_valids", vq.size(), 10);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      run_txn(8'($urandom), 4'(n));
      check_reads("rand", n);
      chk("rand_busy_cycles", busy_cyc, tot(n));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
    end

    clear_stats();
    for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
    cmd = 8'h11; num_reads = 4'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    target = C0 + PER + 3;
    for (int k = 0; k < 200 && m_off != target; k++) begin @(posedge clk); #2; end
    chk("mr_reached", m_off, target);
    chk("mr_rd_low", rd, 0);
    reset = 1'b1;
    #1;
    chk("mr_cs", cs, 1); chk("mr_rd", rd, 1); chk("mr_wr", wr, 1); chk("mr_rs", rs, 1);
    chk("mr_oe", lcd_data_oe, 0); chk("mr_busy", busy, 0); chk("mr_rd_data", rd_data, 0);
    chk("mr_dout", lcd_data_out, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mr_valids", vq.size(), 1);
    chk("mr_done_cnt", done_cnt, 0);
    run_txn(8'hD3, 4'd4);
    check_reads("mr_after", 4);
    chk("mr_after_done", done_cnt, 1);

    for (int k = 0; k < 16; k++) words[k] = 16'h1000 + 16'(k);
    run_txn(8'h04, 4'd15);
    check_reads("n15", 15);
    if (vq.size() == 15) begin
      chk("n15_w14", vq[14], 16'h100E);
      chk("n15_last_to_done", done_cyc - cq[14], RDH);
    end
    chk("n15_busy_cycles", busy_cyc, 217);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
